multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Multicycle successor to the single-cycle MIPS opcode decoder: an FSM that sequences each instruction over 3–5 cycles plus memory wait states.
- Drives the shared-memory multicycle datapath: PC, IR, register file, ALU source muxes and memory strobes.
- Adds over the single-cycle decoder: a latched opcode, a memory ready handshake, a parametrised ALUOp width, an illegal-opcode flag and a retired-instruction counter.

Parameters:
- ALUOP_W, 4, width of ALUOp; codes below are zero-extended to this width.
- MEM_WAIT_EN, 1, 1: memory states wait for mem_ready; 0: mem_ready is treated as constant 1.
- CNT_W, 32, width of instr_count.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  6  IR[31:26]; sampled only in DECODE.
- mem_ready  in  1  memory completion for the current read/write.
- PCWrite  out  1  unconditional PC load.
- PCWriteCond  out  1  conditional PC load; datapath qualifies with PcOp/zero.
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
- IRWrite  out  1  IR load.
- MemRead  out  1  memory read strobe.
- MemWrite  out  1  memory write strobe.
- MemtoReg  out  1  writeback data select: 1 = MDR.
- ALUSrcA  out  1  0 = PC, 1 = rs.
- ALUSrcB  out  2  00 = rt, 01 = const 4, 10 = imm, 11 = imm<<2.
- ALUOp  out  ALUOP_W  ALU operation code.
- RegDest  out  2  00 = rt, 01 = rd, 10 = $31.
- RegWrite  out  1  register file write.
- PcOp  out  2  01 = beq, 10 = bne, 11 = jump.
- isJAL  out  1  writeback data = PC.
- isSigned  out  1  sign-extend immediate.
- Branch  out  1  branch in progress.
- illegal  out  1  one-cycle pulse on an unknown opcode.
- instr_count  out  CNT_W  retired instructions.
- state  out  4  current state encoding, for debug.

Behaviour:
- Reset:
  - Async on rst_n=0: state=FETCH(0), op_q=0, instr_count=0.
  - While rst_n=0, every output is forced to 0.
- Outputs are Moore, decoded from state and op_q. Any signal not listed for a state is 0.
- Opcode latch: op_q <= opcode on the DECODE cycle; every later state uses op_q only.
- mem_ready (rdy) is a level. In a wait state, the strobe (MemRead/MemWrite) is held until the cycle rdy=1, and the state advances on that edge.
- States (encoding: outputs -> next):
  - FETCH 0: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=0000; IRWrite=PCWrite=rdy -> DECODE if rdy, else stay.
  - DECODE 1: ALUSrcA=0, ALUSrcB=11, ALUOp=0000, isSigned=1.
    - 000000 -> EXEC_R.
    - 001000/001100/001101/001110/001010/001011/001111 -> EXEC_I.
    - 100011/101011 -> MEM_ADDR.
    - 000100/000101 -> BRANCH.
    - 000010/000011 -> JUMP.
    - any other opcode: illegal=1 -> FETCH.
  - EXEC_R 2: ALUSrcA=1, ALUSrcB=00, ALUOp=0010 -> ALU_WB.
  - EXEC_I 3: ALUSrcA=1, ALUSrcB=10 -> ALU_WB. ALUOp/isSigned by op_q:
    - addi 0000/1
    - andi 0100/0
    - ori 0101/0
    - xori 0110/0
    - slti 0011/1
    - sltiu 1000/1
    - lui 0111/0
  - ALU_WB 4: RegWrite=1, MemtoReg=0, RegDest=01 if op_q=0 else 00 -> FETCH.
  - MEM_ADDR 5: ALUSrcA=1, ALUSrcB=10, ALUOp=0000, isSigned=1 -> MEM_READ if lw, MEM_WRITE if sw.
  - MEM_READ 6: MemRead=1, IorD=1 -> MEM_WB on rdy, else stay.
  - MEM_WB 7: RegWrite=1, MemtoReg=1, RegDest=00 -> FETCH.
  - MEM_WRITE 8: MemWrite=1, IorD=1 -> FETCH on rdy, else stay.
  - BRANCH 9: ALUSrcA=1, ALUSrcB=00, ALUOp=0001, isSigned=1, Branch=1, PCWriteCond=1, PcOp=01 (beq) or 10 (bne) -> FETCH.
  - JUMP 10: PCWrite=1, PcOp=11; if jal also RegWrite=1, RegDest=10, isJAL=1 -> FETCH.
  - Encodings 11–15: all outputs 0 -> FETCH next cycle; never reached in normal operation.
- instr_count increments by 1, wrapping at 2^CNT_W, on each transition into FETCH from ALU_WB, MEM_WB, MEM_WRITE (with rdy), BRANCH or JUMP. An illegal opcode does not count.
- Latencies with rdy=1 and excluding memory waits: R/I-type 4 cycles, lw 5, sw 4, branch 3, jump 3.
- Reset mid-instruction (including during a wait state): the instruction is abandoned and strobes drop asynchronously; nothing is retired.
- MEM_WAIT_EN=0: every wait state lasts exactly one cycle regardless of mem_ready.

Test Plan:
- Reset, then rdy=1 and opcode=000000 -> states 0,1,2,4,0; in state 4 RegWrite=1 and RegDest=01; instr_count=1.
- lw (100011) with rdy low for 3 cycles in MEM_READ -> MemRead/IorD held 4 cycles; MEM_WB asserts RegWrite=1, MemtoReg=1; 8 cycles total.
- Each I-type opcode -> EXEC_I ALUOp/isSigned exactly per the table; opcode changed after DECODE has no effect (op_q latched).
- bne (000101) -> BRANCH with PcOp=10, PCWriteCond=1, Branch=1; jal (000011) -> JUMP with RegDest=10, isJAL=1, RegWrite=1, PCWrite=1.
- opcode=111111 -> illegal pulses exactly 1 cycle in DECODE; returns to FETCH; instr_count unchanged.
- rst_n low during MEM_WRITE wait -> MemWrite=0 immediately; after release state=0 and instr_count=0. With CNT_W=4, 16 retired instructions wrap instr_count to 0.

Source files
------------

// File: rtl/multicycle_control_if.sv
// Control bus between the multicycle control FSM and the shared-memory datapath.
// The master side is the control unit. It receives the opcode and memory
// ready, and it drives every datapath strobe and mux select.
interface multicycle_control_if #(
  parameter int ALUOP_W = 4,
  parameter int CNT_W   = 32
);
  // datapath -> control
  logic [5:0]         opcode;
  logic               mem_ready;
  // control -> datapath
  logic               PCWrite;
  logic               PCWriteCond;
  logic               IorD;
  logic               IRWrite;
  logic               MemRead;
  logic               MemWrite;
  logic               MemtoReg;
  logic               ALUSrcA;
  logic [1:0]         ALUSrcB;
  logic [ALUOP_W-1:0] ALUOp;
  logic [1:0]         RegDest;
  logic               RegWrite;
  logic [1:0]         PcOp;
  logic               isJAL;
  logic               isSigned;
  logic               Branch;
  logic               illegal;
  logic [CNT_W-1:0]   instr_count;
  logic [3:0]         state;

  modport master (
    input  opcode, mem_ready,
    output PCWrite, PCWriteCond, IorD, IRWrite, MemRead, MemWrite, MemtoReg,
           ALUSrcA, ALUSrcB, ALUOp, RegDest, RegWrite, PcOp, isJAL, isSigned,
           Branch, illegal, instr_count, state
  );

  modport slave (
    output opcode, mem_ready,
    input  PCWrite, PCWriteCond, IorD, IRWrite, MemRead, MemWrite, MemtoReg,
           ALUSrcA, ALUSrcB, ALUOp, RegDest, RegWrite, PcOp, isJAL, isSigned,
           Branch, illegal, instr_count, state
  );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle MIPS control unit. This FSM sequences each instruction through
// fetch, decode, execute, memory and writeback. The opcode is latched in
// DECODE. Memory states wait on mem_ready. The unit also counts retired
// instructions.
module multicycle_control #(
  parameter int ALUOP_W     = 4,
  parameter bit MEM_WAIT_EN = 1'b1,
  parameter int CNT_W       = 32
) (
  input  logic clk,
  input  logic rst_n,
  multicycle_control_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_EXEC_R    = 4'd2,
    S_EXEC_I    = 4'd3,
    S_ALU_WB    = 4'd4,
    S_MEM_ADDR  = 4'd5,
    S_MEM_READ  = 4'd6,
    S_MEM_WB    = 4'd7,
    S_MEM_WRITE = 4'd8,
    S_BRANCH    = 4'd9,
    S_JUMP      = 4'd10
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // ALU operation codes, zero-extended to the configured ALUOp width
  localparam logic [ALUOP_W-1:0] ALU_ADD  = ALUOP_W'(4'b0000);
  localparam logic [ALUOP_W-1:0] ALU_SUB  = ALUOP_W'(4'b0001);
  localparam logic [ALUOP_W-1:0] ALU_FUNC = ALUOP_W'(4'b0010);
  localparam logic [ALUOP_W-1:0] ALU_SLT  = ALUOP_W'(4'b0011);
  localparam logic [ALUOP_W-1:0] ALU_AND  = ALUOP_W'(4'b0100);
  localparam logic [ALUOP_W-1:0] ALU_OR   = ALUOP_W'(4'b0101);
  localparam logic [ALUOP_W-1:0] ALU_XOR  = ALUOP_W'(4'b0110);
  localparam logic [ALUOP_W-1:0] ALU_LUI  = ALUOP_W'(4'b0111);
  localparam logic [ALUOP_W-1:0] ALU_SLTU = ALUOP_W'(4'b1000);

  state_t           r_state;
  logic [5:0]       r_op;
  logic [CNT_W-1:0] r_count;

  logic               w_rdy;
  logic               w_pc_write;
  logic               w_pc_write_cond;
  logic               w_iord;
  logic               w_ir_write;
  logic               w_mem_read;
  logic               w_mem_write;
  logic               w_mem_to_reg;
  logic               w_alu_src_a;
  logic [1:0]         w_alu_src_b;
  logic [ALUOP_W-1:0] w_alu_op;
  logic [1:0]         w_reg_dest;
  logic               w_reg_write;
  logic [1:0]         w_pc_op;
  logic               w_is_jal;
  logic               w_is_signed;
  logic               w_branch;
  logic               w_illegal;

  // With waiting disabled, each memory state completes in one cycle.
  assign w_rdy = MEM_WAIT_EN ? bus.mem_ready : 1'b1;

  // An opcode is legal when some execution path handles it.
  function automatic logic f_legal(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI, OP_SLTIU, OP_LUI,
      OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_JAL: f_legal = 1'b1;
      default:                                    f_legal = 1'b0;
    endcase
  endfunction

  // State sequencing, opcode latch and retired-instruction counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
      r_op    <= 6'd0;
      r_count <= '0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (w_rdy) r_state <= S_DECODE;
        end
        S_DECODE: begin
          r_op <= bus.opcode;
          case (bus.opcode)
            OP_RTYPE:                         r_state <= S_EXEC_R;
            OP_ADDI, OP_ANDI, OP_ORI, OP_XORI,
            OP_SLTI, OP_SLTIU, OP_LUI:        r_state <= S_EXEC_I;
            OP_LW, OP_SW:                     r_state <= S_MEM_ADDR;
            OP_BEQ, OP_BNE:                   r_state <= S_BRANCH;
            OP_J, OP_JAL:                     r_state <= S_JUMP;
            default:                          r_state <= S_FETCH;
          endcase
        end
        S_EXEC_R:   r_state <= S_ALU_WB;
        S_EXEC_I:   r_state <= S_ALU_WB;
        S_MEM_ADDR: r_state <= (r_op == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
        S_MEM_READ: begin
          if (w_rdy) r_state <= S_MEM_WB;
        end
        S_MEM_WRITE: begin
          if (w_rdy) begin
            r_state <= S_FETCH;
            r_count <= r_count + CNT_W'(1);
          end
        end
        S_ALU_WB, S_MEM_WB, S_BRANCH, S_JUMP: begin
          r_state <= S_FETCH;
          r_count <= r_count + CNT_W'(1);
        end
        default:    r_state <= S_FETCH;
      endcase
    end
  end

  // Control decode from the current state and latched opcode.
  // Everything is held at 0 while reset is asserted.
  always_comb begin
    w_pc_write      = 1'b0;
    w_pc_write_cond = 1'b0;
    w_iord          = 1'b0;
    w_ir_write      = 1'b0;
    w_mem_read      = 1'b0;
    w_mem_write     = 1'b0;
    w_mem_to_reg    = 1'b0;
    w_alu_src_a     = 1'b0;
    w_alu_src_b     = 2'b00;
    w_alu_op        = ALU_ADD;
    w_reg_dest      = 2'b00;
    w_reg_write     = 1'b0;
    w_pc_op         = 2'b00;
    w_is_jal        = 1'b0;
    w_is_signed     = 1'b0;
    w_branch        = 1'b0;
    w_illegal       = 1'b0;
    if (rst_n) begin
      case (r_state)
        S_FETCH: begin
          w_mem_read  = 1'b1;
          w_alu_src_b = 2'b01;
          w_ir_write  = w_rdy;
          w_pc_write  = w_rdy;
        end
        S_DECODE: begin
          // branch target PC + (imm<<2) is precomputed here
          w_alu_src_b = 2'b11;
          w_is_signed = 1'b1;
          w_illegal   = ~f_legal(bus.opcode);
        end
        S_EXEC_R: begin
          w_alu_src_a = 1'b1;
          w_alu_op    = ALU_FUNC;
        end
        S_EXEC_I: begin
          w_alu_src_a = 1'b1;
          w_alu_src_b = 2'b10;
          case (r_op)
            OP_ADDI:  begin w_alu_op = ALU_ADD;  w_is_signed = 1'b1; end
            OP_ANDI:  begin w_alu_op = ALU_AND;  w_is_signed = 1'b0; end
            OP_ORI:   begin w_alu_op = ALU_OR;   w_is_signed = 1'b0; end
            OP_XORI:  begin w_alu_op = ALU_XOR;  w_is_signed = 1'b0; end
            OP_SLTI:  begin w_alu_op = ALU_SLT;  w_is_signed = 1'b1; end
            OP_SLTIU: begin w_alu_op = ALU_SLTU; w_is_signed = 1'b1; end
            OP_LUI:   begin w_alu_op = ALU_LUI;  w_is_signed = 1'b0; end
            default:  begin w_alu_op = ALU_ADD;  w_is_signed = 1'b0; end
          endcase
        end
        S_ALU_WB: begin
          w_reg_write = 1'b1;
          w_reg_dest  = (r_op == OP_RTYPE) ? 2'b01 : 2'b00;
        end
        S_MEM_ADDR: begin
          w_alu_src_a = 1'b1;
          w_alu_src_b = 2'b10;
          w_is_signed = 1'b1;
        end
        S_MEM_READ: begin
          w_mem_read = 1'b1;
          w_iord     = 1'b1;
        end
        S_MEM_WB: begin
          w_reg_write  = 1'b1;
          w_mem_to_reg = 1'b1;
        end
        S_MEM_WRITE: begin
          w_mem_write = 1'b1;
          w_iord      = 1'b1;
        end
        S_BRANCH: begin
          w_alu_src_a     = 1'b1;
          w_alu_op        = ALU_SUB;
          w_is_signed     = 1'b1;
          w_branch        = 1'b1;
          w_pc_write_cond = 1'b1;
          w_pc_op         = (r_op == OP_BNE) ? 2'b10 : 2'b01;
        end
        S_JUMP: begin
          w_pc_write = 1'b1;
          w_pc_op    = 2'b11;
          if (r_op == OP_JAL) begin
            w_reg_write = 1'b1;
            w_reg_dest  = 2'b10;
            w_is_jal    = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.PCWrite     = w_pc_write;
  assign bus.PCWriteCond = w_pc_write_cond;
  assign bus.IorD        = w_iord;
  assign bus.IRWrite     = w_ir_write;
  assign bus.MemRead     = w_mem_read;
  assign bus.MemWrite    = w_mem_write;
  assign bus.MemtoReg    = w_mem_to_reg;
  assign bus.ALUSrcA     = w_alu_src_a;
  assign bus.ALUSrcB     = w_alu_src_b;
  assign bus.ALUOp       = w_alu_op;
  assign bus.RegDest     = w_reg_dest;
  assign bus.RegWrite    = w_reg_write;
  assign bus.PcOp        = w_pc_op;
  assign bus.isJAL       = w_is_jal;
  assign bus.isSigned    = w_is_signed;
  assign bus.Branch      = w_branch;
  assign bus.illegal     = w_illegal;
  assign bus.instr_count = r_count;
  assign bus.state       = r_state;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control. The stimulus process drives one
// cycle at a time and queues the expected state, controls and count for that
// cycle. A monitor process compares them mid-cycle against the DUT.
module tb_multicycle_control;

  typedef struct packed {
    logic       PCWrite;
    logic       PCWriteCond;
    logic       IorD;
    logic       IRWrite;
    logic       MemRead;
    logic       MemWrite;
    logic       MemtoReg;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [3:0] ALUOp;
    logic [1:0] RegDest;
    logic       RegWrite;
    logic [1:0] PcOp;
    logic       isJAL;
    logic       isSigned;
    logic       Branch;
    logic       illegal;
  } ctrl_t;

  typedef struct {
    logic [3:0] st;
    ctrl_t      c;
    logic [3:0] cnt;
    string      nm;
  } exp_t;

  localparam ctrl_t Z       = '0;
  localparam ctrl_t F0      = '{MemRead:1'b1, ALUSrcB:2'b01, default:'0};
  localparam ctrl_t F1      = '{MemRead:1'b1, ALUSrcB:2'b01, IRWrite:1'b1, PCWrite:1'b1, default:'0};
  localparam ctrl_t DEC     = '{ALUSrcB:2'b11, isSigned:1'b1, default:'0};
  localparam ctrl_t DEC_ILL = '{ALUSrcB:2'b11, isSigned:1'b1, illegal:1'b1, default:'0};
  localparam ctrl_t EXR     = '{ALUSrcA:1'b1, ALUOp:4'b0010, default:'0};
  localparam ctrl_t WB_R    = '{RegWrite:1'b1, RegDest:2'b01, default:'0};
  localparam ctrl_t WB_I    = '{RegWrite:1'b1, default:'0};
  localparam ctrl_t MADDR   = '{ALUSrcA:1'b1, ALUSrcB:2'b10, isSigned:1'b1, default:'0};
  localparam ctrl_t MRD     = '{MemRead:1'b1, IorD:1'b1, default:'0};
  localparam ctrl_t MWB     = '{RegWrite:1'b1, MemtoReg:1'b1, default:'0};
  localparam ctrl_t MWR     = '{MemWrite:1'b1, IorD:1'b1, default:'0};
  localparam ctrl_t BNE     = '{ALUSrcA:1'b1, ALUOp:4'b0001, isSigned:1'b1, Branch:1'b1,
                                PCWriteCond:1'b1, PcOp:2'b10, default:'0};
  localparam ctrl_t BEQ     = '{ALUSrcA:1'b1, ALUOp:4'b0001, isSigned:1'b1, Branch:1'b1,
                                PCWriteCond:1'b1, PcOp:2'b01, default:'0};
  localparam ctrl_t JAL     = '{PCWrite:1'b1, PcOp:2'b11, RegWrite:1'b1, RegDest:2'b10,
                                isJAL:1'b1, default:'0};
  localparam ctrl_t JMP     = '{PCWrite:1'b1, PcOp:2'b11, default:'0};

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  logic [3:0] cnt_model;
  exp_t exp_q[$];

  multicycle_control_if #(.ALUOP_W(4), .CNT_W(4)) bus ();

  multicycle_control #(.ALUOP_W(4), .MEM_WAIT_EN(1'b1), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic ctrl_t exi(input logic [3:0] a, input logic s);
    ctrl_t c;
    c = '0;
    c.ALUSrcA  = 1'b1;
    c.ALUSrcB  = 2'b10;
    c.ALUOp    = a;
    c.isSigned = s;
    return c;
  endfunction

  // Drive one cycle's inputs just after the rising edge and queue its expectation
  task automatic step(input logic r, input logic [5:0] op, input logic rdy,
                      input logic [3:0] st, input ctrl_t c, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n         = r;
    bus.opcode    = op;
    bus.mem_ready = rdy;
    if (!r) cnt_model = 4'd0;
    e.st  = st;
    e.c   = c;
    e.cnt = cnt_model;
    e.nm  = nm;
    exp_q.push_back(e);
  endtask

  task automatic fetch();
    step(1'b1, 6'd0, 1'b1, 4'd0, F1, "fetch");
  endtask

  task automatic retire();
    cnt_model = cnt_model + 4'd1;
  endtask

  // Monitor: every queued cycle is compared mid-cycle, away from the edge
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t  e;
      ctrl_t a;
      e = exp_q.pop_front();
      a.PCWrite     = bus.PCWrite;
      a.PCWriteCond = bus.PCWriteCond;
      a.IorD        = bus.IorD;
      a.IRWrite     = bus.IRWrite;
      a.MemRead     = bus.MemRead;
      a.MemWrite    = bus.MemWrite;
      a.MemtoReg    = bus.MemtoReg;
      a.ALUSrcA     = bus.ALUSrcA;
      a.ALUSrcB     = bus.ALUSrcB;
      a.ALUOp       = bus.ALUOp;
      a.RegDest     = bus.RegDest;
      a.RegWrite    = bus.RegWrite;
      a.PcOp        = bus.PcOp;
      a.isJAL       = bus.isJAL;
      a.isSigned    = bus.isSigned;
      a.Branch      = bus.Branch;
      a.illegal     = bus.illegal;
      checks = checks + 3;
      if (bus.state !== e.st) begin
        errors = errors + 1;
        $display("FAIL %s state got %0d expected %0d", e.nm, bus.state, e.st);
      end
      if (a !== e.c) begin
        errors = errors + 1;
        $display("FAIL %s ctrl got %06h expected %06h", e.nm, a, e.c);
      end
      if (bus.instr_count !== e.cnt) begin
        errors = errors + 1;
        $display("FAIL %s instr_count got %0d expected %0d", e.nm, bus.instr_count, e.cnt);
      end
      $display("t=%0t %-12s state=%0d ctrl=%06h cnt=%0d", $time, e.nm, bus.state, a, bus.instr_count);
    end
  end

  logic [5:0] i_ops  [7];
  logic [3:0] i_alu  [7];
  logic       i_sgn  [7];

  initial begin
    errors        = 0;
    checks        = 0;
    cnt_model     = 4'd0;
    rst_n         = 1'b0;
    bus.opcode    = 6'd0;
    bus.mem_ready = 1'b0;
    i_ops = '{6'b001000, 6'b001100, 6'b001101, 6'b001110, 6'b001010, 6'b001011, 6'b001111};
    i_alu = '{4'b0000,   4'b0100,   4'b0101,   4'b0110,   4'b0011,   4'b1000,   4'b0111};
    i_sgn = '{1'b1,      1'b0,      1'b0,      1'b0,      1'b1,      1'b1,      1'b0};

    // reset holds all outputs low even though the state is FETCH
    step(1'b0, 6'd0, 1'b0, 4'd0, Z, "reset");
    fetch();

    // R-type: 0,1,2,4,0. Changing the opcode after DECODE must not matter.
    step(1'b1, 6'b000000, 1'b1, 4'd1, DEC,  "r_decode");
    step(1'b1, 6'b111111, 1'b1, 4'd2, EXR,  "r_exec");
    step(1'b1, 6'b111111, 1'b1, 4'd4, WB_R, "r_wb");
    retire();

    // fetch wait, then lw with three not-ready cycles in MEM_READ
    step(1'b1, 6'd0, 1'b0, 4'd0, F0, "fetch_wait");
    fetch();
    step(1'b1, 6'b100011, 1'b1, 4'd1, DEC,   "lw_decode");
    step(1'b1, 6'd0,      1'b1, 4'd5, MADDR, "lw_addr");
    step(1'b1, 6'd0,      1'b0, 4'd6, MRD,   "lw_wait1");
    step(1'b1, 6'd0,      1'b0, 4'd6, MRD,   "lw_wait2");
    step(1'b1, 6'd0,      1'b0, 4'd6, MRD,   "lw_wait3");
    step(1'b1, 6'd0,      1'b1, 4'd6, MRD,   "lw_read");
    step(1'b1, 6'd0,      1'b1, 4'd7, MWB,   "lw_wb");
    retire();
    fetch();

    // every I-type opcode
    for (int k = 0; k < 7; k++) begin
      step(1'b1, i_ops[k], 1'b1, 4'd1, DEC, "i_decode");
      step(1'b1, 6'b111111, 1'b1, 4'd3, exi(i_alu[k], i_sgn[k]), "i_exec");
      step(1'b1, 6'b000000, 1'b1, 4'd4, WB_I, "i_wb");
      retire();
      fetch();
    end

    // branches and jumps
    step(1'b1, 6'b000101, 1'b1, 4'd1, DEC, "bne_decode");
    step(1'b1, 6'b000100, 1'b1, 4'd9, BNE, "bne");
    retire();
    fetch();
    step(1'b1, 6'b000100, 1'b1, 4'd1, DEC, "beq_decode");
    step(1'b1, 6'b000101, 1'b1, 4'd9, BEQ, "beq");
    retire();
    fetch();
    step(1'b1, 6'b000011, 1'b1, 4'd1,  DEC, "jal_decode");
    step(1'b1, 6'b000010, 1'b1, 4'd10, JAL, "jal");
    retire();
    fetch();
    step(1'b1, 6'b000010, 1'b1, 4'd1,  DEC, "j_decode");
    step(1'b1, 6'b000011, 1'b1, 4'd10, JMP, "j");
    retire();
    fetch();

    // sw with one wait cycle
    step(1'b1, 6'b101011, 1'b1, 4'd1, DEC,   "sw_decode");
    step(1'b1, 6'd0,      1'b1, 4'd5, MADDR, "sw_addr");
    step(1'b1, 6'd0,      1'b0, 4'd8, MWR,   "sw_wait");
    step(1'b1, 6'd0,      1'b1, 4'd8, MWR,   "sw_write");
    retire();
    fetch();

    // illegal opcode: one-cycle pulse, back to FETCH, not counted
    step(1'b1, 6'b111111, 1'b1, 4'd1, DEC_ILL, "illegal");
    fetch();

    // reset asserted during a MEM_WRITE wait drops MemWrite at once
    step(1'b1, 6'b101011, 1'b1, 4'd1, DEC,   "sw_decode");
    step(1'b1, 6'd0,      1'b1, 4'd5, MADDR, "sw_addr");
    step(1'b1, 6'd0,      1'b0, 4'd8, MWR,   "sw_wait");
    step(1'b0, 6'd0,      1'b0, 4'd0, Z,     "rst_mid");
    fetch();

    // 16 jumps retire and wrap the 4-bit counter back to 0
    for (int k = 0; k < 16; k++) begin
      step(1'b1, 6'b000010, 1'b1, 4'd1,  DEC, "wrap_decode");
      step(1'b1, 6'd0,      1'b1, 4'd10, JMP, "wrap_jump");
      retire();
      fetch();
    end

    // let the monitor drain the last expectation
    for (int k = 0; k < 4 && exp_q.size() > 0; k++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL drain pending got %0d expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
